rom_reader: RTL

ROM_READER -- requirements
Module: rom_reader

---
 rtl/rom_reader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rom_reader.sv
// rtl/rom_reader.sv - burst reader: issues ROM reads ahead of a small FIFO and streams bytes with backpressure
module rom_reader #(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 8,
    parameter int BUF_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              rom_cs,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remain_q, remain_d;
    logic [DATA_W-1:0]   checksum_q, checksum_d;
    logic                inflight_q, inflight_last_q;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [BUF_DEPTH-1:0] mem_last_q;
    logic [DATA_W-1:0]   mem_data_q [BUF_DEPTH];

    logic            issue, last_issue, push, pop, head_last;
    logic [CNT_W:0]  occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Issue decision looks only at registers so dout_ready never reaches rom_cs.
    assign occ        = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign last_issue = (remain_q == {{ADDR_W{1'b0}}, 1'b1});
    assign issue      = (state_q == FETCH) && (remain_q != '0) && (occ < DEPTH_L);
    assign push       = inflight_q;
    assign head_last  = mem_last_q[rd_ptr_q];

    assign dout_valid = (count_q != '0) && (state_q != DONE);
    assign pop        = dout_valid && dout_ready;
    assign dout       = dout_valid ? mem_data_q[rd_ptr_q] : '0;
    assign dout_last  = dout_valid && head_last;
    assign rom_cs     = issue;
    assign rom_addr   = addr_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign checksum   = checksum_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        checksum_d = checksum_q;
        case (state_q)
            IDLE: if (start) begin
                state_d    = FETCH;
                addr_d     = base_addr;
                remain_d   = {1'b0, len} + (ADDR_W + 1)'(1);
                checksum_d = '0;
            end
            FETCH: if (issue) begin
                addr_d   = addr_q + 1'b1;
                remain_d = remain_q - 1'b1;
                if (last_issue) state_d = DRAIN;
            end
            DRAIN: if (pop && head_last) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (pop) checksum_d = checksum_q + mem_data_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remain_q        <= '0;
            checksum_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            mem_last_q      <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remain_q        <= remain_d;
            checksum_q      <= checksum_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && last_issue;
            if (push) begin
                mem_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) mem_data_q[wr_ptr_q] <= rom_data;
    end
endmodule
